// File: rtl/ahblite_pkg.sv
// ahblite_pkg: shared AHB-Lite encodings, port count and default-slave states.
package ahblite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam int NUM_PORTS = 6;
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_state_e;
endpackage

// File: rtl/ahblite_default_slave.sv
// ahblite_default_slave: two-cycle ERROR responder for unmapped transfers.
// With SLAVEMUX_TIMEOUT_EN it also bounds mapped-slave wait states.
module ahblite_default_slave
  import ahblite_pkg::*;
`ifdef SLAVEMUX_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W = 10
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic hready,
  input  logic def_next,
`ifdef SLAVEMUX_TIMEOUT_EN
  input  logic stall,
  output logic timeout,
  output logic timeout_flag,
`endif
  output logic ds_hreadyout,
  output logic ds_hresp
);
  ds_state_e state, state_d;
`ifdef SLAVEMUX_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  // fire on the edge where the count would reach TIMEOUT_CYCLES-1 while still stalled
  assign timeout = stall && (to_cnt + 1'b1 == TO_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      to_cnt <= '0;
      timeout_flag <= 1'b0;
    end else begin
      to_cnt <= (!stall || hready || timeout) ? '0 : to_cnt + 1'b1;
      if (timeout) timeout_flag <= 1'b1;
    end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= DS_IDLE;
    else state <= state_d;
  always_comb
    state_d = timeout ? DS_ERR1 :
              (state == DS_ERR1) ? DS_ERR2 :
              (hready && def_next) ? DS_ERR1 : DS_IDLE;
  always_comb begin
    ds_hreadyout = state != DS_ERR1;
    ds_hresp = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  end
endmodule

// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux: AHB-Lite data-phase response mux with built-in default ERROR slave.
// Define SLAVEMUX_TIMEOUT_EN to add a wait-state timeout and the TIMEOUT_FLAG port.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W = 10,
  parameter logic [31:0] DEF_RDATA = 32'h0000_0000
)(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P5_HSEL,
  input  logic        P6_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P5_HREADYOUT,
  input  logic        P6_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P5_HRESP,
  input  logic        P6_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P5_HRDATA,
  input  logic [31:0] P6_HRDATA,
`ifdef SLAVEMUX_TIMEOUT_EN
  output logic        TIMEOUT_FLAG,
`endif
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  logic [NUM_PORTS-1:0] hsel, sel_q, rdy, rsp;
  logic [31:0] rd [NUM_PORTS];
  logic [33:0] chain [NUM_PORTS+1];
  logic def_q, def_next, ds_hreadyout, ds_hresp, timeout;
  if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end
  assign hsel = {P6_HSEL, P5_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
  assign rdy = {P6_HREADYOUT, P5_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
  assign rsp = {P6_HRESP, P5_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
  assign rd = '{P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P5_HRDATA, P6_HRDATA};
  assign def_next = ~|hsel && HTRANS[1];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sel_q <= '0;
      def_q <= 1'b0;
    end else if (timeout) begin
      sel_q <= '0;
      def_q <= 1'b0;
    end else if (HREADY) begin
      sel_q <= hsel;
      def_q <= def_next;
    end
  // priority chain: lowest selected port index wins, default slave at the tail
  assign chain[NUM_PORTS] = {ds_hreadyout, ds_hresp, DEF_RDATA};
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_mux
    assign chain[g] = sel_q[g] ? {rdy[g], rsp[g], rd[g]} : chain[g+1];
  end
  assign {HREADYOUT, HRESP, HRDATA} = chain[0];
  a_def_exclusive: assert property (@(posedge HCLK) disable iff (!HRESETn) def_q |-> sel_q == '0);
`ifdef SLAVEMUX_TIMEOUT_EN
  logic stall;
  assign stall = |sel_q && !HREADYOUT;
  ahblite_default_slave #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_ds (
    .clk(HCLK), .rst_n(HRESETn), .hready(HREADY), .def_next(def_next),
    .stall(stall), .timeout(timeout), .timeout_flag(TIMEOUT_FLAG),
    .ds_hreadyout(ds_hreadyout), .ds_hresp(ds_hresp));
`else
  assign timeout = 1'b0;
  ahblite_default_slave u_ds (
    .clk(HCLK), .rst_n(HRESETn), .hready(HREADY), .def_next(def_next),
    .ds_hreadyout(ds_hreadyout), .ds_hresp(ds_hresp));
`endif
endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux: directed self-checking bench for ahblite_slave_mux.
// Port index map in this bench: 0..5 = P0,P1,P2,P3,P5,P6.
module tb_ahblite_slave_mux;
  logic HCLK = 1'b0;
  logic HRESETn;
  logic [1:0] HTRANS;
  logic [5:0] hsel, rdy, rsp;
  logic [31:0] rd [6];
  logic hready, HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [33:0] obs;
  int checks = 0;
  int errors = 0;
`ifdef SLAVEMUX_TIMEOUT_EN
  logic TIMEOUT_FLAG;
`endif
  always #5 HCLK = ~HCLK;
  assign hready = HREADYOUT;
  assign obs = {HREADYOUT, HRESP, HRDATA};

  ahblite_slave_mux #(.TIMEOUT_CYCLES(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(hready), .HTRANS(HTRANS),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]),
    .P3_HSEL(hsel[3]), .P5_HSEL(hsel[4]), .P6_HSEL(hsel[5]),
    .P0_HREADYOUT(rdy[0]), .P1_HREADYOUT(rdy[1]), .P2_HREADYOUT(rdy[2]),
    .P3_HREADYOUT(rdy[3]), .P5_HREADYOUT(rdy[4]), .P6_HREADYOUT(rdy[5]),
    .P0_HRESP(rsp[0]), .P1_HRESP(rsp[1]), .P2_HRESP(rsp[2]),
    .P3_HRESP(rsp[3]), .P5_HRESP(rsp[4]), .P6_HRESP(rsp[5]),
    .P0_HRDATA(rd[0]), .P1_HRDATA(rd[1]), .P2_HRDATA(rd[2]),
    .P3_HRDATA(rd[3]), .P5_HRDATA(rd[4]), .P6_HRDATA(rd[5]),
`ifdef SLAVEMUX_TIMEOUT_EN
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
`endif
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA));

  localparam logic [33:0] OKAY0 = {1'b1, 1'b0, 32'h0};
  localparam logic [33:0] ERR1 = {1'b0, 1'b1, 32'h0};
  localparam logic [33:0] ERR2 = {1'b1, 1'b1, 32'h0};

  task automatic step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic addr(input int port, input logic [1:0] tr);
    hsel = '0;
    if (port >= 0) hsel[port] = 1'b1;
    HTRANS = tr;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    addr(-1, 2'b00);
    #1;
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL reset_asserted got %h want %h", obs, OKAY0); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    step();
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL reset_idle got %h want %h", obs, OKAY0); end
  endtask

  task automatic test_mapped_read();
    addr(1, 2'b10);
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin errors++; $display("FAIL p1_read got %h want %h", obs, {1'b1, 1'b0, 32'hDEAD_BEEF}); end
    addr(-1, 2'b00);
    step();
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL after_p1_idle got %h want %h", obs, OKAY0); end
  endtask

  task automatic test_unmapped();
    addr(-1, 2'b10);
    step();
    checks++;
    if (obs !== ERR1) begin errors++; $display("FAIL unmapped_err1 got %h want %h", obs, ERR1); end
    addr(-1, 2'b00);
    step();
    checks++;
    if (obs !== ERR2) begin errors++; $display("FAIL unmapped_err2 got %h want %h", obs, ERR2); end
    step();
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL unmapped_idle_okay got %h want %h", obs, OKAY0); end
    addr(-1, 2'b01);
    step();
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL unmapped_busy_okay got %h want %h", obs, OKAY0); end
    addr(-1, 2'b00);
  endtask

  task automatic test_stall_switch();
    rdy[3] = 1'b0;
    addr(3, 2'b10);
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h3333_3333}) begin errors++; $display("FAIL p3_stall1 got %h want %h", obs, {1'b0, 1'b0, 32'h3333_3333}); end
    addr(4, 2'b10);
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h3333_3333}) begin errors++; $display("FAIL p3_stall2 got %h want %h", obs, {1'b0, 1'b0, 32'h3333_3333}); end
    step();
    checks++;
    if (obs !== {1'b0, 1'b0, 32'h3333_3333}) begin errors++; $display("FAIL p3_stall3 got %h want %h", obs, {1'b0, 1'b0, 32'h3333_3333}); end
    rdy[3] = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h3333_3333}) begin errors++; $display("FAIL p3_release got %h want %h", obs, {1'b1, 1'b0, 32'h3333_3333}); end
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h5555_5555}) begin errors++; $display("FAIL p5_after_switch got %h want %h", obs, {1'b1, 1'b0, 32'h5555_5555}); end
    addr(-1, 2'b00);
    step();
  endtask

  task automatic test_back_to_back();
    addr(-1, 2'b10);
    step();
    checks++;
    if (obs !== ERR1) begin errors++; $display("FAIL b2b_err1_a got %h want %h", obs, ERR1); end
    step();
    checks++;
    if (obs !== ERR2) begin errors++; $display("FAIL b2b_err2_a got %h want %h", obs, ERR2); end
    step();
    checks++;
    if (obs !== ERR1) begin errors++; $display("FAIL b2b_err1_b got %h want %h", obs, ERR1); end
    addr(0, 2'b10);
    step();
    checks++;
    if (obs !== ERR2) begin errors++; $display("FAIL b2b_err2_b got %h want %h", obs, ERR2); end
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h0A0A_0A0A}) begin errors++; $display("FAIL b2b_p0_data got %h want %h", obs, {1'b1, 1'b0, 32'h0A0A_0A0A}); end
    addr(-1, 2'b00);
    step();
  endtask

  task automatic test_lowest_wins();
    rsp[2] = 1'b1;
    hsel = 6'b010100;
    HTRANS = 2'b10;
    step();
    checks++;
    if (obs !== {1'b1, 1'b1, 32'h2222_2222}) begin errors++; $display("FAIL multi_sel_p2 got %h want %h", obs, {1'b1, 1'b1, 32'h2222_2222}); end
    rsp[2] = 1'b0;
    addr(5, 2'b11);
    step();
    checks++;
    if (obs !== {1'b1, 1'b0, 32'h6666_6666}) begin errors++; $display("FAIL p6_seq got %h want %h", obs, {1'b1, 1'b0, 32'h6666_6666}); end
    addr(-1, 2'b00);
    step();
  endtask

  task automatic test_async_reset();
    addr(-1, 2'b10);
    step();
    checks++;
    if (obs !== ERR1) begin errors++; $display("FAIL pre_reset_err1 got %h want %h", obs, ERR1); end
    addr(-1, 2'b00);
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL mid_reset got %h want %h", obs, OKAY0); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    checks++;
    if (obs !== OKAY0) begin errors++; $display("FAIL post_reset got %h want %h", obs, OKAY0); end
  endtask

`ifdef SLAVEMUX_TIMEOUT_EN
  task automatic test_timeout();
    rdy[2] = 1'b0;
    addr(2, 2'b10);
    step();
    addr(-1, 2'b00);
    for (int c = 1; c < 8; c++) begin
      checks++;
      if ({obs[33:32], TIMEOUT_FLAG} !== 3'b000) begin errors++; $display("FAIL to_stall_%0d got %b want 000", c, {obs[33:32], TIMEOUT_FLAG}); end
      step();
    end
    checks++;
    if ({obs, TIMEOUT_FLAG} !== {ERR1, 1'b1}) begin errors++; $display("FAIL to_err1 got %h want %h", {obs, TIMEOUT_FLAG}, {ERR1, 1'b1}); end
    rdy[2] = 1'b1;
    step();
    checks++;
    if ({obs, TIMEOUT_FLAG} !== {ERR2, 1'b1}) begin errors++; $display("FAIL to_err2 got %h want %h", {obs, TIMEOUT_FLAG}, {ERR2, 1'b1}); end
    step();
    checks++;
    if ({obs, TIMEOUT_FLAG} !== {OKAY0, 1'b1}) begin errors++; $display("FAIL to_sticky got %h want %h", {obs, TIMEOUT_FLAG}, {OKAY0, 1'b1}); end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (TIMEOUT_FLAG !== 1'b0) begin errors++; $display("FAIL to_flag_reset got %b want 0", TIMEOUT_FLAG); end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask
`endif

  initial begin
    rdy = '1;
    rsp = '0;
    rd = '{32'h0A0A_0A0A, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333, 32'h5555_5555, 32'h6666_6666};
    test_reset();
    test_mapped_read();
    test_unmapped();
    test_stall_switch();
    test_back_to_back();
    test_lowest_wins();
    test_async_reset();
`ifdef SLAVEMUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Data-phase response multiplexer sitting directly downstream of the AHB-Lite address decoder.
- Registers the decoder's one-hot port selects during the address phase, then routes the selected slave's HRDATA/HREADYOUT/HRESP back to the Cortex-M0 master.
- Contains a built-in default slave that returns an AHB ERROR for active transfers to unmapped addresses.
- Serves ports P0 (RAMCODE), P1 (RAMDATA), P2 (LCD), P3 (UART), P5 (LED) and P6 (Buzzer).

Parameters:
- TIMEOUT_CYCLES, 1023: data-phase wait-state limit before a forced ERROR; used only with SLAVEMUX_TIMEOUT_EN.
- TO_W, 10: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- DEF_RDATA, 32'h0000_0000: HRDATA value driven when the default slave owns the data phase.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- HREADY  in  1  bus HREADY; this block's HREADYOUT fed back.
- HTRANS  in  2  current address-phase transfer type.
- P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P5_HSEL, P6_HSEL  in  1 each  decoder selects.
- P0/P1/P2/P3/P5/P6_HREADYOUT  in  1 each  slave ready.
- P0/P1/P2/P3/P5/P6_HRESP  in  1 each  slave response.
- P0/P1/P2/P3/P5/P6_HRDATA  in  32 each  slave read data.
- HREADYOUT  out  1  muxed ready to master and all slaves.
- HRESP  out  1  muxed response.
- HRDATA  out  32  muxed read data.
- TIMEOUT_FLAG  out  1  sticky timeout indicator; present only with SLAVEMUX_TIMEOUT_EN.

Behaviour:
- Reset (async, on HRESETn=0):
  - sel_q=6'b0, def_q=0, FSM=DS_IDLE.
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=DEF_RDATA.
  - Reset asserted mid-transfer abandons the transfer immediately.
- Address-phase capture, on HCLK rising edge when HREADY=1:
  - sel_q <= {P6,P5,P3,P2,P1,P0}_HSEL.
  - def_q <= (no HSEL asserted) && HTRANS[1].
  - When HREADY=0, sel_q and def_q hold.
- Output mux:
  - Purely combinational from sel_q and slave outputs; zero added latency.
  - If multiple sel_q bits are set (illegal; decoder ranges are disjoint), the lowest port index wins.
  - If sel_q==0, the default-slave outputs are driven.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: HREADYOUT=1, HRESP=0 (zero-wait OKAY). Covers IDLE/BUSY transfers to unmapped addresses.
  - Capture with def_q=1 -> DS_ERR1.
  - DS_ERR1: HREADYOUT=0, HRESP=1; always -> DS_ERR2.
  - DS_ERR2: HREADYOUT=1, HRESP=1. Goes to DS_ERR1 if the concurrent capture is again unmapped and active; otherwise -> DS_IDLE.
  - Back-to-back unmapped accesses therefore cost exactly 2 cycles each.
- A mapped slave holding HREADYOUT=0 stalls the bus indefinitely, unless the optional feature is compiled in.
- A transition from a mapped port to an unmapped address (or the reverse) takes effect only at an HREADY=1 edge; no cycle ever mixes two sources.

Optional Feature:
- Macro: SLAVEMUX_TIMEOUT_EN.
- With the macro defined:
  - to_cnt (TO_W bits) increments each cycle that a mapped port is in data phase with its HREADYOUT=0.
  - to_cnt clears on that HREADYOUT=1, on any capture, and on reset.
  - When to_cnt reaches TIMEOUT_CYCLES-1 while still stalled: sel_q clears, FSM enters DS_ERR1, and the two-cycle ERROR is issued regardless of the slave.
  - TIMEOUT_FLAG sets and stays at 1 until reset.
  - A late HREADYOUT from the abandoned slave is ignored.
- Without the macro: no counter, no TIMEOUT_FLAG port, unbounded wait states.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ encodings.
  - HRESP_OKAY/HRESP_ERROR.
  - NUM_PORTS=6.
  - DS_IDLE/DS_ERR1/DS_ERR2 state encodings.
- One sub-module, ahblite_default_slave: contains the FSM (and the timeout counter when enabled). Outputs ds_hreadyout and ds_hresp.
- The top level contains only sel_q/def_q capture and the mux.

Test Plan:
- Reset release, no traffic -> HREADYOUT=1, HRESP=0, HRDATA=32'h0 held.
- NONSEQ read with P1_HSEL=1, P1_HRDATA=32'hDEAD_BEEF, P1_HREADYOUT=1 -> next cycle HRDATA=32'hDEAD_BEEF, HREADYOUT=1, HRESP=0.
- NONSEQ with all HSEL=0 -> data phase cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; IDLE with all HSEL=0 -> OKAY, zero wait.
- P3 stalls 3 cycles (HREADYOUT=0) while HSEL changes to P5 -> sel_q stays P3 throughout, P5 selected only after the HREADY=1 edge.
- Back-to-back unmapped NONSEQ, then NONSEQ to P0 -> ERR1, ERR2, ERR1, ERR2, then P0 data, with no OKAY gap between the errors.
- With SLAVEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, P2_HREADYOUT held 0 -> ERROR begins on stall cycle 8, TIMEOUT_FLAG=1 until HRESETn=0.
